mc_ctrl_fsm: RTL

//  Multicycle control FSM; upstream driver of the nbit_reg write enables (PC, IR, MDR, A/B, ALUOut) and datapath muxes.

---
 rtl/mc_ctrl_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/execute per opcode, stalls on MemReady.
// Optional CTRL_PERF_CNT_EN adds CycleCnt/InstrCnt performance counters.
module mc_ctrl_fsm #(
   parameter int unsigned OP_W = 6
`ifdef CTRL_PERF_CNT_EN
   ,
   parameter int unsigned CNT_WIDTH = 32
`endif
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [OP_W-1:0] Op,
   input  logic            Zero,
   input  logic            MemReady,
   output logic            PCEn,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MDRWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSource,
   output logic            IllegalOp,
`ifdef CTRL_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0] CycleCnt,
   output logic [CNT_WIDTH-1:0] InstrCnt,
`endif
   output logic [3:0]      State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

   state_t state_q, state_d;

   logic       pc_write, pc_write_cond;
   logic       iord_c, memread_c, memwrite_c, irwrite_c, mdrwrite_c;
   logic       regdst_c, memtoreg_c, regwrite_c, alusrca_c, illegal_c;
   logic [1:0] alusrcb_c, aluop_c, pcsource_c;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord_c        = 1'b0;
      memread_c     = 1'b0;
      memwrite_c    = 1'b0;
      irwrite_c     = 1'b0;
      mdrwrite_c    = 1'b0;
      regdst_c      = 1'b0;
      memtoreg_c    = 1'b0;
      regwrite_c    = 1'b0;
      alusrca_c     = 1'b0;
      alusrcb_c     = 2'd0;
      aluop_c       = 2'd0;
      pcsource_c    = 2'd0;
      illegal_c     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            memread_c = 1'b1;
            alusrcb_c = 2'd1;
            if (MemReady) begin
               irwrite_c = 1'b1;
               pc_write  = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is resolved
            alusrcb_c = 2'd3;
            unique case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  illegal_c = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'd2;
            if (Op == OP_LW)      state_d = S_MEMRD;
            else if (Op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD: begin
            memread_c = 1'b1;
            iord_c    = 1'b1;
            if (MemReady) begin
               mdrwrite_c = 1'b1;
               state_d    = S_MEMWB;
            end
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            memwrite_c = 1'b1;
            iord_c     = 1'b1;
            if (MemReady) state_d = S_FETCH;
         end
         S_EXEC: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'd2;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            regdst_c   = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca_c     = 1'b1;
            aluop_c       = 2'd1;
            pcsource_c    = 2'd1;
            pc_write_cond = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pcsource_c = 2'd2;
            pc_write   = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'd2;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // All control outputs are held low combinationally while reset is asserted
   always_comb begin
      PCEn      = Reset & (pc_write | (pc_write_cond & Zero));
      IorD      = Reset & iord_c;
      MemRead   = Reset & memread_c;
      MemWrite  = Reset & memwrite_c;
      IRWrite   = Reset & irwrite_c;
      MDRWrite  = Reset & mdrwrite_c;
      RegDst    = Reset & regdst_c;
      MemtoReg  = Reset & memtoreg_c;
      RegWrite  = Reset & regwrite_c;
      ALUSrcA   = Reset & alusrca_c;
      ALUSrcB   = Reset ? alusrcb_c  : 2'd0;
      ALUOp     = Reset ? aluop_c    : 2'd0;
      PCSource  = Reset ? pcsource_c : 2'd0;
      IllegalOp = Reset & illegal_c;
      State     = state_q;
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cyc_q, cyc_d, instr_q, instr_d;

   always_comb begin
      cyc_d   = cyc_q + 1'b1;
      instr_d = instr_q;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_d = instr_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cyc_q   <= '0;
         instr_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         instr_q <= instr_d;
      end
   end

   assign CycleCnt = cyc_q;
   assign InstrCnt = instr_q;
`endif

endmodule
